// File: rtl/gpu_bg_pkg.sv
// Shared types and widths for the GPU BG block transfer engine.
package gpu_bg_pkg;

    localparam int unsigned BG_BLOCK_W = 256;
    localparam int unsigned BG_MASK_W  = 16;
    localparam int unsigned BG_ADR_W   = 15;
    localparam int unsigned MEM_BEAT_W = 64;
    localparam int unsigned MEM_BE_W   = 8;
    localparam int unsigned BEAT_IDX_W = 2;

    typedef enum logic [2:0] {
        IDLE,
        WR_CMD,
        WR_DATA,
        RD_CMD,
        RD_DATA
    } bg_xfer_state_t;

    // Contents of the SAVE holding slot.
    typedef struct packed {
        logic [BG_ADR_W-1:0]   adr;
        logic [BG_BLOCK_W-1:0] block;
        logic [BG_MASK_W-1:0]  mask;
    } bg_save_t;

endpackage

// File: rtl/gpu_bg_block_transfer_if.sv
// Memory-side command / write-data / read-data bundle of the BG block transfer engine.
interface gpu_bg_block_transfer_if;
    import gpu_bg_pkg::*;

    logic                  o_cmdValid;
    logic                  i_cmdReady;
    logic                  o_cmdWrite;
    logic [BG_ADR_W-1:0]   o_cmdAdr;
    logic                  o_wrValid;
    logic                  i_wrReady;
    logic [MEM_BEAT_W-1:0] o_wrData;
    logic [MEM_BE_W-1:0]   o_wrBE;
    logic                  i_rdValid;
    logic [MEM_BEAT_W-1:0] i_rdData;

    modport master (
        output o_cmdValid, o_cmdWrite, o_cmdAdr, o_wrValid, o_wrData, o_wrBE,
        input  i_cmdReady, i_wrReady, i_rdValid, i_rdData
    );

    modport slave (
        input  o_cmdValid, o_cmdWrite, o_cmdAdr, o_wrValid, o_wrData, o_wrBE,
        output i_cmdReady, i_wrReady, i_rdValid, i_rdData
    );

endinterface

// File: rtl/gpu_bg_beat_mux.sv
// Selects one 64-bit memory beat and its byte enables from a 16-pixel block and pixel mask.
module gpu_bg_beat_mux
    import gpu_bg_pkg::*;
(
    input  logic [BG_BLOCK_W-1:0] block_i,
    input  logic [BG_MASK_W-1:0]  mask_i,
    input  logic [BEAT_IDX_W-1:0] beat_i,
    output logic [MEM_BEAT_W-1:0] data_o,
    output logic [MEM_BE_W-1:0]   be_o
);

    logic [3:0] pix_en;

    // Each pixel is two bytes, so every mask bit drives a byte-enable pair.
    always_comb begin
        data_o = block_i[{beat_i, 6'd0} +: MEM_BEAT_W];
        pix_en = mask_i[{beat_i, 2'd0} +: 4];
        be_o   = {{2{pix_en[3]}}, {2{pix_en[2]}}, {2{pix_en[1]}}, {2{pix_en[0]}}};
    end

endmodule

// File: rtl/gpu_bg_block_transfer.sv
// Writes exported BG blocks back to memory and fetches the next block for the pixel backend;
// saves are always drained before loads so a reload observes the freshly written data.
module gpu_bg_block_transfer
    import gpu_bg_pkg::*;
#(
    parameter bit          SKIP_EMPTY_SAVE = 1'b1,
    parameter int unsigned BEATS           = 4
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_saveReq,
    input  logic [BG_ADR_W-1:0]   i_saveAdr,
    input  logic [BG_BLOCK_W-1:0] i_saveBlock,
    input  logic [BG_MASK_W-1:0]  i_saveMask,
    input  logic                  i_loadReq,
    input  logic [BG_ADR_W-1:0]   i_loadAdr,
    output logic                  o_busy,
    output logic                  o_importValid,
    output logic [BG_BLOCK_W-1:0] o_importBlock,
    output logic                  o_overflow,
    gpu_bg_block_transfer_if.master mem
);

    localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(BEATS - 1);

    bg_xfer_state_t        state_q, state_d;
    logic [BEAT_IDX_W-1:0] beat_q, beat_d;
    bg_save_t              save_q, save_d;
    logic                  save_full_q, save_full_d;
    logic [BG_ADR_W-1:0]   load_adr_q, load_adr_d;
    logic                  load_full_q, load_full_d;
    logic                  overflow_q, overflow_d;
    logic [BG_BLOCK_W-1:0] import_block_q, import_block_d;
    logic                  import_valid_q, import_valid_d;
    logic                  cmd_valid_q, cmd_valid_d;
    logic                  cmd_write_q, cmd_write_d;
    logic [BG_ADR_W-1:0]   cmd_adr_q, cmd_adr_d;
    logic                  wr_valid_q, wr_valid_d;
    logic [MEM_BEAT_W-1:0] wr_data_q, wr_data_d;
    logic [MEM_BE_W-1:0]   wr_be_q, wr_be_d;
    logic                  save_clr, load_clr;
    logic [MEM_BEAT_W-1:0] mux_data;
    logic [MEM_BE_W-1:0]   mux_be;

    gpu_bg_beat_mux u_beat_mux (
        .block_i (save_q.block),
        .mask_i  (save_q.mask),
        .beat_i  (beat_d),
        .data_o  (mux_data),
        .be_o    (mux_be)
    );

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q        <= IDLE;
            beat_q         <= '0;
            save_q         <= '0;
            save_full_q    <= 1'b0;
            load_adr_q     <= '0;
            load_full_q    <= 1'b0;
            overflow_q     <= 1'b0;
            import_block_q <= '0;
            import_valid_q <= 1'b0;
            cmd_valid_q    <= 1'b0;
            cmd_write_q    <= 1'b0;
            cmd_adr_q      <= '0;
            wr_valid_q     <= 1'b0;
            wr_data_q      <= '0;
            wr_be_q        <= '0;
        end else begin
            state_q        <= state_d;
            beat_q         <= beat_d;
            save_q         <= save_d;
            save_full_q    <= save_full_d;
            load_adr_q     <= load_adr_d;
            load_full_q    <= load_full_d;
            overflow_q     <= overflow_d;
            import_block_q <= import_block_d;
            import_valid_q <= import_valid_d;
            cmd_valid_q    <= cmd_valid_d;
            cmd_write_q    <= cmd_write_d;
            cmd_adr_q      <= cmd_adr_d;
            wr_valid_q     <= wr_valid_d;
            wr_data_q      <= wr_data_d;
            wr_be_q        <= wr_be_d;
        end
    end

    // Transfer sequencing and holding-slot bookkeeping.
    always_comb begin
        state_d        = state_q;
        beat_d         = beat_q;
        save_d         = save_q;
        save_full_d    = save_full_q;
        load_adr_d     = load_adr_q;
        load_full_d    = load_full_q;
        overflow_d     = overflow_q;
        import_block_d = import_block_q;
        import_valid_d = 1'b0;
        save_clr       = 1'b0;
        load_clr       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (save_full_q && ((|save_q.mask) || !SKIP_EMPTY_SAVE)) begin
                    state_d = WR_CMD;
                end else if (save_full_q) begin
                    save_clr = 1'b1;
                end else if (load_full_q) begin
                    state_d = RD_CMD;
                end
            end
            WR_CMD: begin
                if (mem.i_cmdReady) begin
                    state_d = WR_DATA;
                    beat_d  = '0;
                end
            end
            WR_DATA: begin
                if (mem.i_wrReady) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d  = IDLE;
                        save_clr = 1'b1;
                    end else begin
                        beat_d = BEAT_IDX_W'(beat_q + 1'b1);
                    end
                end
            end
            RD_CMD: begin
                if (mem.i_cmdReady) begin
                    state_d = RD_DATA;
                    beat_d  = '0;
                end
            end
            RD_DATA: begin
                if (mem.i_rdValid) begin
                    import_block_d[{beat_q, 6'd0} +: MEM_BEAT_W] = mem.i_rdData;
                    if (beat_q == LAST_BEAT) begin
                        state_d        = IDLE;
                        load_clr       = 1'b1;
                        import_valid_d = 1'b1;
                    end else begin
                        beat_d = BEAT_IDX_W'(beat_q + 1'b1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (save_clr) save_full_d = 1'b0;
        if (load_clr) load_full_d = 1'b0;

        // A request that finds its slot still occupied (even one clearing now) is lost.
        if (i_saveReq) begin
            if (save_full_q) begin
                overflow_d = 1'b1;
            end else begin
                save_d      = '{adr: i_saveAdr, block: i_saveBlock, mask: i_saveMask};
                save_full_d = 1'b1;
            end
        end
        if (i_loadReq) begin
            if (load_full_q) begin
                overflow_d = 1'b1;
            end else begin
                load_adr_d  = i_loadAdr;
                load_full_d = 1'b1;
            end
        end
    end

    // Memory-side outputs are registered from the next state so they hold steady until accepted.
    always_comb begin
        cmd_valid_d = (state_d == WR_CMD) || (state_d == RD_CMD);
        cmd_write_d = (state_d == WR_CMD);
        cmd_adr_d   = '0;
        if (state_d == WR_CMD) cmd_adr_d = save_q.adr;
        if (state_d == RD_CMD) cmd_adr_d = load_adr_q;
        wr_valid_d  = (state_d == WR_DATA);
        wr_data_d   = wr_valid_d ? mux_data : '0;
        wr_be_d     = wr_valid_d ? mux_be : '0;
    end

    assign o_busy          = (state_q != IDLE) | save_full_q | load_full_q | i_saveReq | i_loadReq;
    assign o_importValid   = import_valid_q;
    assign o_importBlock   = import_block_q;
    assign o_overflow      = overflow_q;
    assign mem.o_cmdValid  = cmd_valid_q;
    assign mem.o_cmdWrite  = cmd_write_q;
    assign mem.o_cmdAdr    = cmd_adr_q;
    assign mem.o_wrValid   = wr_valid_q;
    assign mem.o_wrData    = wr_data_q;
    assign mem.o_wrBE      = wr_be_q;

endmodule

// File: tb/tb_gpu_bg_block_transfer.sv
// Directed bench for gpu_bg_block_transfer with a queue scoreboard for commands, write beats and imports.
module tb_gpu_bg_block_transfer;
    import gpu_bg_pkg::*;

    typedef struct packed {
        logic                wr;
        logic [BG_ADR_W-1:0] adr;
    } cmd_t;

    typedef struct packed {
        logic [MEM_BEAT_W-1:0] data;
        logic [MEM_BE_W-1:0]   be;
    } wr_t;

    logic                  clk = 1'b0;
    logic                  i_rst;
    logic                  i_saveReq;
    logic [BG_ADR_W-1:0]   i_saveAdr;
    logic [BG_BLOCK_W-1:0] i_saveBlock;
    logic [BG_MASK_W-1:0]  i_saveMask;
    logic                  i_loadReq;
    logic [BG_ADR_W-1:0]   i_loadAdr;
    logic                  o_busy;
    logic                  o_importValid;
    logic [BG_BLOCK_W-1:0] o_importBlock;
    logic                  o_overflow;

    gpu_bg_block_transfer_if mem ();

    gpu_bg_block_transfer #(.SKIP_EMPTY_SAVE(1'b1), .BEATS(4)) dut (
        .clk           (clk),
        .i_rst         (i_rst),
        .i_saveReq     (i_saveReq),
        .i_saveAdr     (i_saveAdr),
        .i_saveBlock   (i_saveBlock),
        .i_saveMask    (i_saveMask),
        .i_loadReq     (i_loadReq),
        .i_loadAdr     (i_loadAdr),
        .o_busy        (o_busy),
        .o_importValid (o_importValid),
        .o_importBlock (o_importBlock),
        .o_overflow    (o_overflow),
        .mem           (mem)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int wr_acc   = 0;
    cmd_t                  exp_cmd[$];
    wr_t                   exp_wr[$];
    logic [BG_BLOCK_W-1:0] exp_imp[$];
    logic busy_s;
    logic prev_imp;
    bit   rd_cmd_seen;
    bit   imp_seen;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] m_data(input logic [255:0] blk, input int k);
        return 64'(blk >> (64 * k));
    endfunction

    function automatic logic [7:0] m_be(input logic [15:0] mask, input int k);
        logic [3:0] nib;
        logic [7:0] be;
        nib = 4'(mask >> (4 * k));
        be  = 8'h00;
        for (int j = 0; j < 4; j++)
            if (nib[j]) be = be | (8'b11 << (2 * j));
        return be;
    endfunction

    function automatic logic [255:0] mk_blk(input logic [15:0] seed);
        logic [255:0] b;
        b = '0;
        for (int n = 15; n >= 0; n--)
            b = (b << 16) | 256'(16'(seed + 16'(n * 16'h0111)));
        return b;
    endfunction

    // Sample at the falling edge, then advance to just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        busy_s = o_busy;
        if (mem.o_cmdValid === 1'b1) begin
            if (exp_cmd.size() == 0) begin
                check("cmd_valid_unexpected", 256'(mem.o_cmdValid), 256'(0));
            end else begin
                check("cmd_write", 256'(mem.o_cmdWrite), 256'(exp_cmd[0].wr));
                check("cmd_adr", 256'(mem.o_cmdAdr), 256'(exp_cmd[0].adr));
                if (mem.i_cmdReady) begin
                    if (!exp_cmd[0].wr) begin
                        rd_cmd_seen = 1'b1;
                        check("write_beats_before_read", 256'(exp_wr.size()), 256'(0));
                    end
                    void'(exp_cmd.pop_front());
                end
            end
        end
        if (mem.o_wrValid === 1'b1) begin
            if (exp_wr.size() == 0) begin
                check("wr_valid_unexpected", 256'(mem.o_wrValid), 256'(0));
            end else begin
                check("wr_data", 256'(mem.o_wrData), 256'(exp_wr[0].data));
                check("wr_be", 256'(mem.o_wrBE), 256'(exp_wr[0].be));
                if (mem.i_wrReady) begin
                    wr_acc++;
                    void'(exp_wr.pop_front());
                end
            end
        end
        if (o_importValid === 1'b1) begin
            if (exp_imp.size() == 0) begin
                check("import_valid_unexpected", 256'(o_importValid), 256'(0));
            end else begin
                check("import_block", o_importBlock, exp_imp.pop_front());
                imp_seen = 1'b1;
            end
        end
        if (prev_imp === 1'b1) check("import_pulse_width", 256'(o_importValid), 256'(0));
        prev_imp = o_importValid;
        @(posedge clk);
        #1;
    endtask

    task automatic push_save(input logic [14:0] adr, input logic [255:0] blk, input logic [15:0] mask);
        if (mask != 16'h0) begin
            exp_cmd.push_back(cmd_t'{wr: 1'b1, adr: adr});
            for (int k = 0; k < 4; k++)
                exp_wr.push_back(wr_t'{data: m_data(blk, k), be: m_be(mask, k)});
        end
    endtask

    task automatic drive_save(input logic [14:0] adr, input logic [255:0] blk, input logic [15:0] mask);
        i_saveReq   = 1'b1;
        i_saveAdr   = adr;
        i_saveBlock = blk;
        i_saveMask  = mask;
    endtask

    task automatic wait_idle(input string tag, input int budget, output int n);
        n = 0;
        while (busy_s !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_idle_timeout"}, 256'(busy_s), 256'(0));
    endtask

    task automatic wait_rd_cmd(input string tag, input int budget);
        int n;
        n = 0;
        while (!rd_cmd_seen && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_rd_cmd_timeout"}, 256'(rd_cmd_seen), 256'(1));
    endtask

    initial begin
        int n;
        int acc0;
        logic [255:0] blk;

        i_rst = 1'b1; i_saveReq = 1'b0; i_saveAdr = '0; i_saveBlock = '0; i_saveMask = '0;
        i_loadReq = 1'b0; i_loadAdr = '0;
        mem.i_cmdReady = 1'b0; mem.i_wrReady = 1'b0; mem.i_rdValid = 1'b0; mem.i_rdData = '0;
        prev_imp = 1'b0; rd_cmd_seen = 1'b0; imp_seen = 1'b0; busy_s = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_busy", 256'(o_busy), 256'(0));
        check("rst_import_valid", 256'(o_importValid), 256'(0));
        check("rst_import_block", o_importBlock, 256'(0));
        check("rst_overflow", 256'(o_overflow), 256'(0));
        check("rst_cmd_valid", 256'(mem.o_cmdValid), 256'(0));
        check("rst_cmd_write", 256'(mem.o_cmdWrite), 256'(0));
        check("rst_cmd_adr", 256'(mem.o_cmdAdr), 256'(0));
        check("rst_wr_valid", 256'(mem.o_wrValid), 256'(0));
        check("rst_wr_data", 256'(mem.o_wrData), 256'(0));
        check("rst_wr_be", 256'(mem.o_wrBE), 256'(0));
        i_rst = 1'b0;
        mem.i_cmdReady = 1'b1; mem.i_wrReady = 1'b1;
        tick();

        // Simple save, full mask: busy covers request cycle through the last beat (7 cycles)
        blk = mk_blk(16'h1000);
        drive_save(15'h0123, blk, 16'hFFFF);
        push_save(15'h0123, blk, 16'hFFFF);
        tick();
        i_saveReq = 1'b0;
        check("save_busy_on_req", 256'(busy_s), 256'(1));
        wait_idle("simple_save", 30, n);
        check("simple_save_busy_cycles", 256'(n), 256'(7));

        // Partial mask
        blk = mk_blk(16'h2000);
        drive_save(15'h0456, blk, 16'h8001);
        push_save(15'h0456, blk, 16'h8001);
        tick();
        i_saveReq = 1'b0;
        wait_idle("partial", 30, n);

        // Empty mask is dropped without any bus traffic
        drive_save(15'h0789, mk_blk(16'h3000), 16'h0000);
        tick();
        i_saveReq = 1'b0;
        wait_idle("empty", 30, n);
        check("empty_busy_cycles", 256'(n), 256'(2));

        // Stray read beat while idle must be ignored
        mem.i_rdValid = 1'b1; mem.i_rdData = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
        mem.i_rdValid = 1'b0;

        // Save and load of the same block in one cycle: write completes before the read
        blk = mk_blk(16'h4000);
        drive_save(15'h0040, blk, 16'h0F0F);
        push_save(15'h0040, blk, 16'h0F0F);
        i_loadReq = 1'b1; i_loadAdr = 15'h0040;
        exp_cmd.push_back(cmd_t'{wr: 1'b0, adr: 15'h0040});
        exp_imp.push_back({64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
        rd_cmd_seen = 1'b0; imp_seen = 1'b0;
        tick();
        i_saveReq = 1'b0; i_loadReq = 1'b0;
        wait_rd_cmd("save_load", 40);
        for (int k = 0; k < 4; k++) begin
            mem.i_rdValid = 1'b1;
            mem.i_rdData  = 64'h1111_1111_1111_1111 * 64'(k + 1);
            tick();
        end
        mem.i_rdValid = 1'b0;
        tick();
        check("save_load_import_seen", 256'(imp_seen), 256'(1));
        wait_idle("save_load", 20, n);

        // Backpressure: stalled command, then toggling write ready; exactly 4 beats
        mem.i_cmdReady = 1'b0; mem.i_wrReady = 1'b0;
        blk = mk_blk(16'h5000);
        drive_save(15'h02AB, blk, 16'h5A3C);
        push_save(15'h02AB, blk, 16'h5A3C);
        acc0 = wr_acc;
        tick();
        i_saveReq = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        mem.i_cmdReady = 1'b1;
        n = 0;
        while (busy_s !== 1'b0 && n < 60) begin
            mem.i_wrReady = ~mem.i_wrReady;
            tick();
            n++;
        end
        check("backpressure_idle_timeout", 256'(busy_s), 256'(0));
        check("backpressure_beat_count", 256'(wr_acc - acc0), 256'(4));
        mem.i_wrReady = 1'b1;

        // Overflow: a second save while the first is in WR_DATA is dropped
        mem.i_wrReady = 1'b0;
        blk = mk_blk(16'h6000);
        drive_save(15'h0111, blk, 16'hFFFF);
        push_save(15'h0111, blk, 16'hFFFF);
        tick();
        i_saveReq = 1'b0;
        n = 0;
        while (mem.o_wrValid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("overflow_wr_valid_timeout", 256'(mem.o_wrValid), 256'(1));
        drive_save(15'h0222, mk_blk(16'h7000), 16'hFFFF);
        tick();
        i_saveReq = 1'b0;
        check("overflow_set", 256'(o_overflow), 256'(1));
        mem.i_wrReady = 1'b1;
        wait_idle("overflow", 30, n);
        check("overflow_sticky", 256'(o_overflow), 256'(1));

        // Reset in the middle of RD_DATA abandons the load
        i_loadReq = 1'b1; i_loadAdr = 15'h1234;
        exp_cmd.push_back(cmd_t'{wr: 1'b0, adr: 15'h1234});
        rd_cmd_seen = 1'b0;
        tick();
        i_loadReq = 1'b0;
        wait_rd_cmd("rst_mid", 20);
        for (int k = 0; k < 2; k++) begin
            mem.i_rdValid = 1'b1;
            mem.i_rdData  = 64'hA5A5_0000_0000_0000 + 64'(k);
            tick();
        end
        mem.i_rdValid = 1'b0;
        i_rst = 1'b1;
        tick();
        check("mid_rst_busy", 256'(o_busy), 256'(0));
        check("mid_rst_import_valid", 256'(o_importValid), 256'(0));
        check("mid_rst_import_block", o_importBlock, 256'(0));
        check("mid_rst_overflow", 256'(o_overflow), 256'(0));
        check("mid_rst_cmd_valid", 256'(mem.o_cmdValid), 256'(0));
        check("mid_rst_wr_valid", 256'(mem.o_wrValid), 256'(0));
        i_rst = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("post_rst_busy", 256'(busy_s), 256'(0));

        check("leftover_cmds", 256'(exp_cmd.size()), 256'(0));
        check("leftover_wr_beats", 256'(exp_wr.size()), 256'(0));
        check("leftover_imports", 256'(exp_imp.size()), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
